// File: rtl/poly_coeff_modmul_stream.sv
// Lane-parallel streaming (a * operand) mod Q with a per-polynomial operation:
// negacyclic twist, untwist+scale, pointwise product or scale by N^-1.
module poly_coeff_modmul_stream #(
    parameter int unsigned  W         = 32,
    parameter int unsigned  N         = 8,
    parameter int unsigned  LANES     = 2,
    parameter logic [W-1:0] Modulus_Q = 32'd2147483777,
    parameter logic [W-1:0] PSI       = 32'd1323801281,
    parameter logic [W-1:0] PSI_INV   = 32'd2145878094,
    parameter logic [W-1:0] N_INV     = 32'd1879048305
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_mode,
    input  logic [LANES*W-1:0]   in_a,
    input  logic [LANES*W-1:0]   in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*W-1:0]   out_data,
    output logic [1:0]           out_mode,
    output logic                 out_last
);

    localparam int unsigned       BEATS     = N / LANES;
    localparam int unsigned       BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [2*W-1:0]    Q_WIDE    = {{W{1'b0}}, Modulus_Q};

    localparam logic [1:0] MODE_TWIST     = 2'd0;
    localparam logic [1:0] MODE_UNTWIST   = 2'd1;
    localparam logic [1:0] MODE_POINTWISE = 2'd2;
    localparam logic [1:0] MODE_SCALE     = 2'd3;

    function automatic logic [W-1:0] mul_mod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        return W'(p % Q_WIDE);
    endfunction

    function automatic logic [W-1:0] pow_mod(input logic [W-1:0] base, input int unsigned e);
        logic [W-1:0] r;
        r = W'(1);
        for (int unsigned k = 0; k < e; k++) begin
            r = mul_mod(r, base);
        end
        return r;
    endfunction

    // Tables are arranged per lane so the beat counter indexes them directly.
    logic [W-1:0] tw_tab [LANES][BEATS];
    logic [W-1:0] ut_tab [LANES][BEATS];

    for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
        for (genvar gk = 0; gk < BEATS; gk++) begin : g_beat
            localparam int unsigned  IDX  = gk * LANES + gl;
            localparam logic [W-1:0] TW_C = pow_mod(PSI, IDX);
            localparam logic [W-1:0] UT_C = mul_mod(N_INV, pow_mod(PSI_INV, IDX));
            assign tw_tab[gl][gk] = TW_C;
            assign ut_tab[gl][gk] = UT_C;
        end
    end

    logic [BEAT_W-1:0]      in_beat_q, in_beat_d;
    logic [1:0]             mode_q, mode_d;
    logic                   v1_q, v1_d;
    logic [LANES*W-1:0]     a1_q, a1_d;
    logic [LANES*W-1:0]     op1_q, op1_d;
    logic [1:0]             mode1_q, mode1_d;
    logic                   last1_q, last1_d;
    logic                   v2_q, v2_d;
    logic [LANES*2*W-1:0]   prod2_q, prod2_d;
    logic [1:0]             mode2_q, mode2_d;
    logic                   last2_q, last2_d;
    logic                   out_valid_q, out_valid_d;
    logic [LANES*W-1:0]     out_data_q, out_data_d;
    logic [1:0]             out_mode_q, out_mode_d;
    logic                   out_last_q, out_last_d;

    logic                   stall;
    logic                   accept;
    logic [1:0]             cur_mode;
    logic [LANES*W-1:0]     op_sel;

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && !stall;
    // The first beat of a polynomial takes its mode straight from the port.
    assign cur_mode = (in_beat_q == '0) ? in_mode : mode_q;

    always_comb begin
        op_sel = '0;
        for (int l = 0; l < LANES; l++) begin
            unique case (cur_mode)
                MODE_TWIST:     op_sel[l*W +: W] = tw_tab[l][in_beat_q];
                MODE_UNTWIST:   op_sel[l*W +: W] = ut_tab[l][in_beat_q];
                MODE_POINTWISE: op_sel[l*W +: W] = in_b[l*W +: W];
                MODE_SCALE:     op_sel[l*W +: W] = N_INV;
                default:        op_sel[l*W +: W] = '0;
            endcase
        end
    end

    always_comb begin
        in_beat_d   = in_beat_q;
        mode_d      = mode_q;
        v1_d        = v1_q;
        a1_d        = a1_q;
        op1_d       = op1_q;
        mode1_d     = mode1_q;
        last1_d     = last1_q;
        v2_d        = v2_q;
        prod2_d     = prod2_q;
        mode2_d     = mode2_q;
        last2_d     = last2_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_mode_d  = out_mode_q;
        out_last_d  = out_last_q;

        if (!stall) begin
            v1_d = accept;
            if (accept) begin
                a1_d      = in_a;
                op1_d     = op_sel;
                mode1_d   = cur_mode;
                last1_d   = (in_beat_q == LAST_BEAT);
                in_beat_d = (in_beat_q == LAST_BEAT) ? '0 : in_beat_q + BEAT_W'(1);
                if (in_beat_q == '0) begin
                    mode_d = in_mode;
                end
            end

            v2_d = v1_q;
            if (v1_q) begin
                for (int l = 0; l < LANES; l++) begin
                    prod2_d[l*2*W +: 2*W] = {{W{1'b0}}, a1_q[l*W +: W]} *
                                            {{W{1'b0}}, op1_q[l*W +: W]};
                end
                mode2_d = mode1_q;
                last2_d = last1_q;
            end

            out_valid_d = v2_q;
            out_last_d  = v2_q && last2_q;
            if (v2_q) begin
                for (int l = 0; l < LANES; l++) begin
                    out_data_d[l*W +: W] = W'(prod2_q[l*2*W +: 2*W] % Q_WIDE);
                end
                out_mode_d = mode2_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_beat_q   <= '0;
            mode_q      <= '0;
            v1_q        <= 1'b0;
            a1_q        <= '0;
            op1_q       <= '0;
            mode1_q     <= '0;
            last1_q     <= 1'b0;
            v2_q        <= 1'b0;
            prod2_q     <= '0;
            mode2_q     <= '0;
            last2_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_mode_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            in_beat_q   <= in_beat_d;
            mode_q      <= mode_d;
            v1_q        <= v1_d;
            a1_q        <= a1_d;
            op1_q       <= op1_d;
            mode1_q     <= mode1_d;
            last1_q     <= last1_d;
            v2_q        <= v2_d;
            prod2_q     <= prod2_d;
            mode2_q     <= mode2_d;
            last2_q     <= last2_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_mode_q  <= out_mode_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_mode  = out_mode_q;
    assign out_last  = out_last_q;

endmodule
